uart_tx_arbiter: RTL and testbench

Two-requester scheduler in front of the board's single UART transmitter. It accepts bytes from two independent sources, for example the PS/2 scan-code path and a status/echo path. It grants them round-robin and issues one start strobe per byte to the transmitter. It then holds off until the transmitter reports the frame is complete and an optional inter-frame gap has elapsed. A busy-acknowledge timeout recovers the block if the transmitter never responds.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that feeds bytes from two requesters into a single UART
// transmitter, one start strobe per byte, with busy-ack timeout and inter-frame gap.
module uart_tx_arbiter #(
  parameter logic [15:0] GAP_CYCLES  = 16'd16,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       active,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        last_grant;
  logic        sel;
  logic        accept;

  // On a tie the requester that did not win last time gets the byte slot.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  // Readies are held low while reset is asserted even though the state is IDLE.
  assign req0_ready = ~rst & (state == IDLE) & ~sel & req0_valid;
  assign req1_ready = ~rst & (state == IDLE) &  sel & req1_valid;
  assign accept     = req0_ready | req1_ready;

  assign tx_start = (state == START);
  assign active   = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
        end
      end
      START: begin
        cnt_nxt   = ACK_TIMEOUT;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == 16'd0) begin
          // The byte is dropped; the transmitter never acknowledged it.
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES == 16'd0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = GAP_CYCLES;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (cnt <= 16'd1) begin
          cnt_nxt   = 16'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // last_grant starts at 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= 8'h00;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      tx_data    <= sel ? req1_data : req0_data;
      grant_id   <= sel;
      last_grant <= sel;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: two arbiter instances (default timing, and zero gap with a
// short ack timeout) checked every cycle against a transaction-level timing model.
module tb_uart_tx_arbiter;

  localparam int GAP_A = 16;
  localparam int ACK_A = 1023;
  localparam int GAP_B = 0;
  localparam int ACK_B = 5;
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       r0v[2];
  logic       r1v[2];
  logic [7:0] r0d[2];
  logic [7:0] r1d[2];
  logic       busy[2];
  logic       r0r[2];
  logic       r1r[2];
  logic [7:0] txd[2];
  logic       txs[2];
  logic       gid[2];
  logic       act[2];
  logic       terr[2];

  uart_tx_arbiter dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(r0v[0]), .req0_data(r0d[0]), .req0_ready(r0r[0]),
    .req1_valid(r1v[0]), .req1_data(r1d[0]), .req1_ready(r1r[0]),
    .tx_data(txd[0]), .tx_start(txs[0]), .tx_busy(busy[0]),
    .grant_id(gid[0]), .active(act[0]), .timeout_err(terr[0])
  );

  uart_tx_arbiter #(.GAP_CYCLES(16'd0), .ACK_TIMEOUT(16'd5)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(r0v[1]), .req0_data(r0d[1]), .req0_ready(r0r[1]),
    .req1_valid(r1v[1]), .req1_data(r1d[1]), .req1_ready(r1r[1]),
    .tx_data(txd[1]), .tx_start(txs[1]), .tx_busy(busy[1]),
    .grant_id(gid[1]), .active(act[1]), .timeout_err(terr[1])
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         m_idle_at[2];
  int         m_start_at[2];
  int         m_terr_at[2];
  logic       m_last[2];
  logic       m_gid[2];
  logic [7:0] m_data[2];
  logic       e_r0[2];
  logic       e_r1[2];
  logic       e_sel[2];
  logic       e_idle[2];
  int         gen_mode[2];
  int         tx_mode[2];
  logic       pend[2];
  logic [7:0] fix_a[2];
  logic       saw0[2];
  logic       saw1[2];
  int         p_d[2];
  int         p_l[2];
  int         bs[2];
  int         be[2];
  int         terr_cnt[2];
  logic       rec_order = 1'b0;
  logic [7:0] order_q[$];
  logic [7:0] exp_order[4];

  function automatic int gapOf(input int k);
    return (k == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic int ackOf(input int k);
    return (k == 0) ? ACK_A : ACK_B;
  endfunction

  task automatic checkOutput(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d cycle %0d observed=%0b expected=%0b", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      m_idle_at[k]  = 0;
      m_start_at[k] = -1;
      m_terr_at[k]  = -1;
      m_last[k]     = 1'b1;
      m_gid[k]      = 1'b0;
      m_data[k]     = 8'h00;
      bs[k]         = 0;
      be[k]         = 0;
      saw0[k]       = 1'b0;
      saw1[k]       = 1'b0;
      pend[k]       = 1'b0;
      r0v[k]        = 1'b0;
      r1v[k]        = 1'b0;
      busy[k]       = 1'b0;
    end
  endtask

  task automatic randReq(input logic v, input logic saw, input logic [7:0] d,
                         output logic nv, output logic [7:0] nd);
    nv = v;
    nd = d;
    if (v && !saw) begin
      if ($urandom_range(15, 0) == 0) nv = 1'b0;
    end else begin
      nv = ($urandom_range(2, 0) == 0);
      if (nv) nd = 8'($urandom);
    end
  endtask

  task automatic applyStimulus(input int k);
    case (gen_mode[k])
      1: begin
        randReq(r0v[k], saw0[k], r0d[k], r0v[k], r0d[k]);
        randReq(r1v[k], saw1[k], r1d[k], r1v[k], r1d[k]);
      end
      2: begin
        r0v[k] = 1'b1; r0d[k] = 8'h11;
        r1v[k] = 1'b1; r1d[k] = 8'h22;
      end
      3: begin
        if (saw0[k]) pend[k] = 1'b0;
        r0v[k] = pend[k]; r0d[k] = fix_a[k];
        r1v[k] = 1'b0;
      end
      default: begin
        r0v[k] = 1'b0;
        r1v[k] = 1'b0;
      end
    endcase
    busy[k] = (cyc >= bs[k]) && (cyc < be[k]);
  endtask

  // Bench-side transmitter: busy window opens p_d cycles after the strobe it sees.
  task automatic runTransmitter(input int k);
    if (txs[k]) begin
      if (p_d[k] < 0) begin
        bs[k] = NEVER; be[k] = NEVER;
      end else begin
        bs[k] = cyc + p_d[k]; be[k] = bs[k] + p_l[k];
      end
      busy[k] = (cyc >= bs[k]) && (cyc < be[k]);
    end
  endtask

  task automatic predict(input int k);
    e_idle[k] = (cyc >= m_idle_at[k]);
    if (r0v[k] && r1v[k]) e_sel[k] = ~m_last[k];
    else                  e_sel[k] = r1v[k];
    e_r0[k] = e_idle[k] && r0v[k] && !e_sel[k];
    e_r1[k] = e_idle[k] && r1v[k] &&  e_sel[k];
  endtask

  task automatic checkCycle(input int k);
    checkFlag("req0_ready", k, r0r[k], e_r0[k]);
    checkFlag("req1_ready", k, r1r[k], e_r1[k]);
    checkFlag("ready_exclusive", k, r0r[k] & r1r[k], 1'b0);
    checkFlag("active", k, act[k], !e_idle[k]);
    checkFlag("tx_start", k, txs[k], cyc == m_start_at[k]);
    checkFlag("timeout_err", k, terr[k], cyc == m_terr_at[k]);
    checkOutput("tx_data", k, txd[k], m_data[k]);
    checkFlag("grant_id", k, gid[k], m_gid[k]);
    saw0[k] = r0r[k] && r0v[k];
    saw1[k] = r1r[k] && r1v[k];
    if (terr[k]) terr_cnt[k]++;
    if (rec_order && k == 0 && txs[k]) order_q.push_back(txd[k]);
  endtask

  // Frame timing from the accept: strobe next cycle, wait for busy to rise and
  // fall, then the gap; a frame never acknowledged ends with the timeout pulse.
  task automatic updateModel(input int k);
    if (e_r0[k] || e_r1[k]) begin
      m_data[k]     = e_sel[k] ? r1d[k] : r0d[k];
      m_gid[k]      = e_sel[k];
      m_last[k]     = e_sel[k];
      m_start_at[k] = cyc + 1;
      case (tx_mode[k])
        1:       begin p_d[k] = 2;  p_l[k] = 10; end
        2:       begin p_d[k] = -1; p_l[k] = 0; end
        3:       begin p_d[k] = 0;  p_l[k] = int'($urandom_range(6, 2)); end
        default: begin p_d[k] = int'($urandom_range(4, 1)); p_l[k] = int'($urandom_range(6, 1)); end
      endcase
      if (p_d[k] < 0) begin
        m_terr_at[k] = cyc + 2 + ackOf(k);
        m_idle_at[k] = m_terr_at[k] + 1;
      end else begin
        m_idle_at[k] = cyc + 1 + p_d[k] + p_l[k] + gapOf(k) + 1;
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 2; k++) applyStimulus(k);
      #1;
      for (int k = 0; k < 2; k++) runTransmitter(k);
      for (int k = 0; k < 2; k++) predict(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkCycle(k);
        updateModel(k);
      end
    end
  endtask

  task automatic checkResetState(input int k);
    checkFlag("rst_tx_start", k, txs[k], 1'b0);
    checkOutput("rst_tx_data", k, txd[k], 8'h00);
    checkFlag("rst_grant_id", k, gid[k], 1'b0);
    checkFlag("rst_active", k, act[k], 1'b0);
    checkFlag("rst_timeout_err", k, terr[k], 1'b0);
    checkFlag("rst_req0_ready", k, r0r[k], 1'b0);
    checkFlag("rst_req1_ready", k, r1r[k], 1'b0);
  endtask

  // Reset lands mid-cycle; both requesters are valid to show readies stay low.
  task automatic midReset();
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) checkResetState(k);
    for (int k = 0; k < 2; k++) begin
      r0v[k] = 1'b1; r1v[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 2; k++) checkResetState(k);
    @(negedge clk);
    resetModel();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    exp_order = '{8'h11, 8'h22, 8'h11, 8'h22};
    for (int k = 0; k < 2; k++) begin
      r0d[k] = 8'h00; r1d[k] = 8'h00;
      gen_mode[k] = 0; tx_mode[k] = 0;
      fix_a[k] = 8'h00; p_d[k] = 1; p_l[k] = 1; terr_cnt[k] = 0;
    end
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) checkResetState(k);
    rst = 1'b0;

    $display("[TB] single byte A5 on port 0, busy 10 cycles after 2-cycle delay");
    gen_mode[0] = 3; fix_a[0] = 8'hA5; pend[0] = 1'b1; tx_mode[0] = 1;
    runCycles(45);

    $display("[TB] reset during WAIT_DONE");
    pend[0] = 1'b1;
    runCycles(7);
    checkFlag("pre_reset_busy", 0, busy[0], 1'b1);
    midReset();

    $display("[TB] both ports valid continuously");
    gen_mode[0] = 2;
    rec_order = 1'b1;
    runCycles(100);
    rec_order = 1'b0;
    checkFlag("order_len", 0, order_q.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < order_q.size()) checkOutput("order", 0, order_q[i], exp_order[i]);
    end
    gen_mode[0] = 0;
    runCycles(40);

    $display("[TB] randomized traffic on both instances");
    gen_mode[0] = 1; gen_mode[1] = 1;
    tx_mode[0] = 0;  tx_mode[1] = 0;
    runCycles(500);
    gen_mode[0] = 0; gen_mode[1] = 0;
    runCycles(60);

    $display("[TB] ack timeout with busy held low");
    terr_cnt[1] = 0;
    gen_mode[1] = 3; fix_a[1] = 8'h3C; pend[1] = 1'b1; tx_mode[1] = 2;
    runCycles(12);
    checkOutput("timeout_count", 1, 8'(terr_cnt[1]), 8'd1);
    fix_a[1] = 8'h5A; pend[1] = 1'b1; tx_mode[1] = 3;
    runCycles(12);

    $display("[TB] zero gap, busy already high at the strobe");
    gen_mode[1] = 2; tx_mode[1] = 3;
    runCycles(40);
    gen_mode[1] = 0;
    runCycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
